// File: rtl/cla_pkg.sv
// Shared constants, parameter bounds and the per-stage pipeline record for the
// pipelined carry-lookahead adder.
package cla_pkg;

  localparam int GROUP_W    = 4;
  localparam int WIDTH_MIN  = 4;
  localparam int WIDTH_MAX  = 64;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 16;

  // psum is sized for the widest adder; bits above WIDTH stay zero.
  typedef struct packed {
    logic                 vld;
    logic [WIDTH_MAX-1:0] psum;
    logic                 carry;
    logic                 sub;
    logic                 a_msb;
    logic                 b_msb;
  } stage_t;

  function automatic bit params_ok(input int width, input int stages);
    if (width < WIDTH_MIN || width > WIDTH_MAX || (width % GROUP_W) != 0) return 1'b0;
    if (stages < STAGES_MIN || stages > STAGES_MAX) return 1'b0;
    if ((width % stages) != 0) return 1'b0;
    return ((width / stages) % GROUP_W) == 0;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational carry-lookahead adder for one pipeline slice: 4-bit groups with
// full in-group lookahead, group generate/propagate chained between groups.
module cla_slice
  import cla_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  localparam int NG = SLICE_W / GROUP_W;

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] c;
  logic [NG:0]        cg;

  always_comb begin
    logic [GROUP_W-1:0] gg;
    logic [GROUP_W-1:0] pp;
    logic               grp_g;
    logic               grp_p;
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    cg    = '0;
    gg    = '0;
    pp    = '0;
    grp_g = 1'b0;
    grp_p = 1'b0;
    cg[0] = ci;
    for (int j = 0; j < NG; j++) begin
      gg = g[j*GROUP_W +: GROUP_W];
      pp = p[j*GROUP_W +: GROUP_W];
      c[j*GROUP_W]     = cg[j];
      c[j*GROUP_W + 1] = gg[0] | (pp[0] & cg[j]);
      c[j*GROUP_W + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cg[j]);
      c[j*GROUP_W + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                       | (pp[2] & pp[1] & pp[0] & cg[j]);
      grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
            | (pp[3] & pp[2] & pp[1] & gg[0]);
      grp_p = &pp;
      cg[j+1] = grp_g | (grp_p & cg[j]);
    end
  end

  assign s  = p ^ c;
  assign co = cg[NG];

endmodule

// File: rtl/cla_pipe.sv
// Pipelined add/subtract unit: one lookahead slice per stage, slice carries and
// not-yet-added operand bits registered between stages, valid/ready handshake.
module cla_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("cla_pipe: illegal WIDTH=%0d / STAGES=%0d combination", WIDTH, STAGES);
  end

  logic [WIDTH-1:0] bx_in;
  stage_t           out_rec;

  assign bx_in    = sub ? ~b : b;
  assign in_ready = ~(out_valid & ~out_ready);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still waiting for later stages after this one.
    localparam int RW = WIDTH - (k + 1) * SW;

    stage_t          src;
    stage_t          st_d;
    stage_t          st_q;
    logic            ld;
    logic [SW-1:0]   sa;
    logic [SW-1:0]   sb;
    logic [SW-1:0]   ss;
    logic            sco;

    if (k == 0) begin : g_src
      always_comb begin
        src       = '0;
        src.vld   = in_valid;
        src.carry = sub | cin;
        src.sub   = sub;
        src.a_msb = a[WIDTH-1];
        src.b_msb = b[WIDTH-1];
      end
      assign ld = in_valid & in_ready;
      assign sa = a[SW-1:0];
      assign sb = bx_in[SW-1:0];
    end else begin : g_src
      assign src = g_stage[k-1].st_q;
      assign ld  = in_ready;
      assign sa  = g_stage[k-1].g_ops.a_q[SW-1:0];
      assign sb  = g_stage[k-1].g_ops.bx_q[SW-1:0];
    end

    cla_slice #(.SLICE_W(SW)) u_slice (
      .a  (sa),
      .b  (sb),
      .ci (src.carry),
      .s  (ss),
      .co (sco)
    );

    always_comb begin
      st_d = st_q;
      if (in_ready) st_d.vld = src.vld;
      if (ld) begin
        st_d.psum              = src.psum;
        st_d.psum[k*SW +: SW]  = ss;
        st_d.carry             = sco;
        st_d.sub               = src.sub;
        st_d.a_msb             = src.a_msb;
        st_d.b_msb             = src.b_msb;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st_q <= '0;
      else        st_q <= st_d;
    end

    if (RW > 0) begin : g_ops
      logic [RW-1:0] a_src;
      logic [RW-1:0] bx_src;
      logic [RW-1:0] a_d;
      logic [RW-1:0] a_q;
      logic [RW-1:0] bx_d;
      logic [RW-1:0] bx_q;

      if (k == 0) begin : g_in
        assign a_src  = a[WIDTH-1:SW];
        assign bx_src = bx_in[WIDTH-1:SW];
      end else begin : g_in
        assign a_src  = g_stage[k-1].g_ops.a_q[RW+SW-1:SW];
        assign bx_src = g_stage[k-1].g_ops.bx_q[RW+SW-1:SW];
      end

      always_comb begin
        a_d  = ld ? a_src  : a_q;
        bx_d = ld ? bx_src : bx_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q  <= '0;
          bx_q <= '0;
        end else begin
          a_q  <= a_d;
          bx_q <= bx_d;
        end
      end
    end
  end

  assign out_rec   = g_stage[STAGES-1].st_q;
  assign out_valid = out_rec.vld;
  assign sum       = out_rec.psum[WIDTH-1:0];
  assign cout      = out_rec.carry;
  // Overflow compares against the effective second operand's sign.
  assign ovf       = (out_rec.a_msb == (out_rec.b_msb ^ out_rec.sub))
                   & (out_rec.psum[WIDTH-1] != out_rec.a_msb);
  assign zero      = ~|out_rec.psum;

endmodule

// File: tb/tb_cla_pipe.sv
// Bench for cla_pipe: three configurations (16/2, 32/4, 64/1) checked against an
// arithmetic reference model through per-cycle scoreboards.
module tb_cla_pipe;

  localparam int WID [3] = '{16, 32, 64};
  localparam int STG [3] = '{2, 4, 1};

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic dv [3];
  logic dr [3];
  logic dc [3];
  logic ds [3];
  logic [63:0] da [3];
  logic [63:0] db [3];

  logic [63:0] vsum [3];
  logic vov [3], vir [3], vco [3], vof [3], vz [3];

  logic        ir0, ov0, co0, of0, z0;
  logic [15:0] s0;
  logic        ir1, ov1, co1, of1, z1;
  logic [31:0] s1;
  logic        ir2, ov2, co2, of2, z2;
  logic [63:0] s2;

  cla_pipe #(.WIDTH(16), .STAGES(2)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(dv[0]), .in_ready(ir0),
    .a(da[0][15:0]), .b(db[0][15:0]), .cin(dc[0]), .sub(ds[0]),
    .out_valid(ov0), .out_ready(dr[0]), .sum(s0), .cout(co0), .ovf(of0), .zero(z0));

  cla_pipe #(.WIDTH(32), .STAGES(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(dv[1]), .in_ready(ir1),
    .a(da[1][31:0]), .b(db[1][31:0]), .cin(dc[1]), .sub(ds[1]),
    .out_valid(ov1), .out_ready(dr[1]), .sum(s1), .cout(co1), .ovf(of1), .zero(z1));

  cla_pipe #(.WIDTH(64), .STAGES(1)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(dv[2]), .in_ready(ir2),
    .a(da[2]), .b(db[2]), .cin(dc[2]), .sub(ds[2]),
    .out_valid(ov2), .out_ready(dr[2]), .sum(s2), .cout(co2), .ovf(of2), .zero(z2));

  assign vsum[0] = 64'(s0);
  assign vsum[1] = 64'(s1);
  assign vsum[2] = s2;
  assign vov[0] = ov0;  assign vov[1] = ov1;  assign vov[2] = ov2;
  assign vir[0] = ir0;  assign vir[1] = ir1;  assign vir[2] = ir2;
  assign vco[0] = co0;  assign vco[1] = co1;  assign vco[2] = co2;
  assign vof[0] = of0;  assign vof[1] = of1;  assign vof[2] = of2;
  assign vz[0]  = z0;   assign vz[1]  = z1;   assign vz[2]  = z2;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   lat_chk [3];
  bit   rnd_rdy [3];
  res_t expq [3][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic for sum/cout, signed range test for ovf.
  function automatic res_t ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
    res_t r;
    logic [67:0] mask, ua, ub, ut;
    logic signed [67:0] sa, sb, st, lim;
    mask = (68'd1 << w) - 68'd1;
    ua   = {4'd0, a} & mask;
    ub   = {4'd0, b} & mask;
    if (sub) ut = ua - ub;
    else     ut = ua + ub + {67'd0, cin};
    r.sum  = ut[63:0] & mask[63:0];
    r.cout = sub ? (ua >= ub) : ut[w];
    lim = 68'sd1 <<< (w - 1);
    sa  = $signed(ua);
    sb  = $signed(ub);
    if (ua[w-1]) sa = sa - (lim <<< 1);
    if (ub[w-1]) sb = sb - (lim <<< 1);
    st = sub ? (sa - sb) : (sa + sb + $signed({67'd0, cin}));
    r.ovf  = (st >= lim) || (st < -lim);
    r.zero = (r.sum == 64'd0);
    r.acc  = 0;
    return r;
  endfunction

  task automatic mon(input int i);
    res_t e;
    check($sformatf("in_ready[%0d]", i), vir[i], !(vov[i] && !dr[i]));
    if (vov[i]) begin
      check($sformatf("expected_beat[%0d]", i), expq[i].size() > 0, 1);
      if (expq[i].size() > 0) begin
        e = expq[i][0];
        check($sformatf("sum[%0d]", i),  vsum[i], e.sum);
        check($sformatf("cout[%0d]", i), vco[i],  e.cout);
        check($sformatf("ovf[%0d]", i),  vof[i],  e.ovf);
        check($sformatf("zero[%0d]", i), vz[i],   e.zero);
        if (dr[i]) begin
          if (lat_chk[i]) check($sformatf("latency[%0d]", i), cyc - e.acc, STG[i]);
          void'(expq[i].pop_front());
        end
      end
    end
    if (dv[i] && vir[i]) begin
      e = ref_add(WID[i], da[i], db[i], dc[i], ds[i]);
      e.acc = cyc;
      expq[i].push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) mon(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (rnd_rdy[i]) dr[i] = ($urandom_range(0, 9) < 7);
  endtask

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = 64'd0;
      2: v = 64'h8000_0000_0000_8000 | (v & 64'h0000_0000_0000_7FFF);
      default: ;
    endcase
    return v;
  endfunction

  task automatic send(input int i, input logic [63:0] a, input logic [63:0] b,
                      input logic c, input logic s);
    bit acc;
    int n;
    n = 0;
    dv[i] = 1'b1; da[i] = a; db[i] = b; dc[i] = c; ds[i] = s;
    do begin
      @(negedge clk);
      acc = vir[i];
      tick();
      n++;
    end while (!acc && n < 100);
    check($sformatf("accept_timeout[%0d]", i), acc, 1);
  endtask

  task automatic idle(input int i, input int n);
    dv[i] = 1'b0;
    da[i] = {$urandom, $urandom};
    db[i] = {$urandom, $urandom};
    dc[i] = $urandom_range(0, 1);
    ds[i] = $urandom_range(0, 1);
    repeat (n) tick();
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    dv[i] = 1'b0;
    while (expq[i].size() > 0 && n < 200) begin
      tick();
      n++;
    end
    tick();
    check($sformatf("drained[%0d]", i), expq[i].size(), 0);
  endtask

  task automatic rand_phase(input int i, input int beats);
    lat_chk[i] = 1'b0;
    rnd_rdy[i] = 1'b1;
    for (int n = 0; n < beats; n++) begin
      if ($urandom_range(0, 3) == 0) idle(i, 1);
      send(i, rnd_op(), rnd_op(), $urandom_range(0, 1), $urandom_range(0, 1));
    end
    rnd_rdy[i] = 1'b0;
    dr[i] = 1'b1;
    drain(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    res_t r;
    logic [63:0] snap_sum;
    logic        snap_co, snap_of, snap_z;

    for (int i = 0; i < 3; i++) begin
      dv[i] = 0; dr[i] = 0; dc[i] = 0; ds[i] = 0; da[i] = '0; db[i] = '0;
      lat_chk[i] = 0; rnd_rdy[i] = 0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_out_valid[%0d]", i), vov[i], 0);
      check($sformatf("rst_sum[%0d]", i), vsum[i], 0);
      check($sformatf("rst_cout[%0d]", i), vco[i], 0);
      check($sformatf("rst_ovf[%0d]", i), vof[i], 0);
      check($sformatf("rst_zero[%0d]", i), vz[i], 1);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("in_ready_after_rst[%0d]", i), vir[i], 1);
    tick();
    for (int i = 0; i < 3; i++) dr[i] = 1'b1;

    // Hand-computed pins on the reference model.
    r = ref_add(16, 64'hFFFF, 64'h0001, 1'b0, 1'b0);
    check("pin_ffff_sum", r.sum, 64'h0); check("pin_ffff_cout", r.cout, 1);
    check("pin_ffff_zero", r.zero, 1);   check("pin_ffff_ovf", r.ovf, 0);
    r = ref_add(16, 64'h7FFF, 64'h0001, 1'b0, 1'b0);
    check("pin_7fff_sum", r.sum, 64'h8000); check("pin_7fff_ovf", r.ovf, 1);
    check("pin_7fff_cout", r.cout, 0);
    r = ref_add(16, 64'h0005, 64'h0007, 1'b1, 1'b1);
    check("pin_sub_sum", r.sum, 64'hFFFE); check("pin_sub_cout", r.cout, 0);
    check("pin_sub_ovf", r.ovf, 0);
    r = ref_add(64, '1, 64'h0, 1'b1, 1'b0);
    check("pin_w64_sum", r.sum, 64'h0); check("pin_w64_cout", r.cout, 1);
    check("pin_w64_zero", r.zero, 1);

    // 16-bit, 2 stages: carry across the slice boundary, exact latency.
    lat_chk[0] = 1'b1;
    send(0, 64'hFFFF, 64'h0001, 1'b0, 1'b0);
    dv[0] = 1'b0;
    @(negedge clk);
    check("w16_lat_early_valid", ov0, 0);
    tick();
    @(negedge clk);
    check("w16_lat2_valid", ov0, 1);
    check("w16_lat2_sum", s0, 16'h0000);
    check("w16_lat2_cout", co0, 1);
    check("w16_lat2_zero", z0, 1);
    check("w16_lat2_ovf", of0, 0);
    drain(0);
    send(0, 64'h7FFF, 64'h0001, 1'b0, 1'b0);
    send(0, 64'h0005, 64'h0007, 1'b1, 1'b1);
    idle(0, 1);
    drain(0);
    rand_phase(0, 60);

    // 32-bit, 4 stages: 100 back-to-back beats with out_ready held high.
    lat_chk[1] = 1'b1;
    for (int n = 0; n < 100; n++)
      send(1, rnd_op(), rnd_op(), $urandom_range(0, 1), $urandom_range(0, 1));
    idle(1, 1);
    drain(1);

    // Backpressure: fill the pipe, then stall five cycles.
    lat_chk[1] = 1'b0;
    for (int n = 0; n < 4; n++)
      send(1, rnd_op(), rnd_op(), $urandom_range(0, 1), $urandom_range(0, 1));
    da[1] = rnd_op(); db[1] = rnd_op();
    dr[1] = 1'b0;
    @(negedge clk);
    check("stall_out_valid", ov1, 1);
    snap_sum = vsum[1]; snap_co = co1; snap_of = of1; snap_z = z1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("stall_in_ready", ir1, 0);
      check("stall_sum_stable", vsum[1], snap_sum);
      check("stall_cout_stable", co1, snap_co);
      check("stall_ovf_stable", of1, snap_of);
      check("stall_zero_stable", z1, snap_z);
      tick();
    end
    dr[1] = 1'b1;
    send(1, da[1], db[1], dc[1], ds[1]);
    idle(1, 1);
    drain(1);

    // Reset mid-stream with beats in flight.
    for (int n = 0; n < 5; n++)
      send(1, rnd_op(), rnd_op(), $urandom_range(0, 1), $urandom_range(0, 1));
    dv[1] = 1'b0;
    check("pre_reset_valid", ov1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", ov1, 0);
    check("mid_rst_sum", s1, 32'h0);
    check("mid_rst_zero", z1, 1);
    for (int i = 0; i < 3; i++) expq[i].delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_mid_rst", ir1, 1);
    idle(1, 10);
    check("no_stale_after_rst", ov1, 0);

    // 64-bit, single stage.
    lat_chk[2] = 1'b1;
    send(2, '1, 64'h0, 1'b1, 1'b0);
    dv[2] = 1'b0;
    @(negedge clk);
    check("w64_lat1_valid", ov2, 1);
    check("w64_sum", s2, 64'h0);
    check("w64_cout", co2, 1);
    check("w64_zero", z2, 1);
    drain(2);
    rand_phase(2, 40);

    for (int i = 0; i < 3; i++) check($sformatf("final_empty[%0d]", i), expq[i].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
